// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction-fetch front end: widths, reset PC,
// prefetch FSM encoding and the queue entry payload.
package cpu_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } pq_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] inst;
    } pq_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Synchronous FIFO with flush and a registered head entry, used as the
// instruction prefetch buffer.
module pq_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok    = push & (count != CW'(DEPTH));
    assign pop_ok     = pop & (count != '0);
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head register tracks mem[rd_ptr] so the entry is visible right after its push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (pop_ok) begin
                if (count > CW'(1)) begin
                    head_data <= mem[rd_ptr_nxt];
                end else if (push_ok) begin
                    head_data <= push_data;
                end else begin
                    head_valid <= 1'b0;
                end
            end else if (push_ok && count == '0) begin
                head_data  <= push_data;
                head_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF stage.
// Define PREFETCH_STATS_EN to add the fetch_cnt / flush_cnt statistics ports.
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned           WORD_SIZE = cpu_pkg::WORD_SIZE,
    parameter int unsigned           DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0]  RESET_PC  = cpu_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   i_readM,
    output logic [WORD_SIZE-1:0]   i_address,
    input  logic [WORD_SIZE-1:0]   i_data,
    input  logic                   redirect,
    input  logic [WORD_SIZE-1:0]   redirect_pc,
    input  logic                   deq,
    input  logic                   halt,
    output logic                   inst_valid,
    output logic [WORD_SIZE-1:0]   inst,
    output logic [WORD_SIZE-1:0]   inst_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]            fetch_cnt,
    output logic [15:0]            flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pq_state_t            state;
    logic                 fetch_en;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic                 redirect_eff;
    logic                 push;
    logic                 pop;
    pq_entry_t            push_entry;
    pq_entry_t            head_entry;

    // Redirect is dead once halted; when live it suppresses this cycle's read.
    assign redirect_eff = redirect & (state != HALTED);
    assign push         = fetch_en & ~redirect_eff;
    assign pop          = deq & inst_valid & ~redirect_eff;
    assign i_readM      = push;
    assign i_address    = fetch_pc;
    assign push_entry   = '{pc: fetch_pc, inst: i_data};
    assign inst         = head_entry.inst;
    assign inst_pc      = head_entry.pc;

    pq_fifo #(
        .WIDTH ($bits(pq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_eff),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head_data  (head_entry)
    );

    // fetch_en is the registered read enable: high exactly while the next state is FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= FETCH;
            fetch_en <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                FETCH, FULL: begin
                    if (redirect_eff) begin
                        state    <= FETCH;
                        fetch_en <= 1'b1;
                        fetch_pc <= redirect_pc;
                    end else begin
                        if (push) begin
                            fetch_pc <= fetch_pc + WORD_SIZE'(1);
                        end
                        if (halt) begin
                            state    <= HALTED;
                            fetch_en <= 1'b0;
                        end else if (state == FETCH) begin
                            if (push && !pop && count == CW'(DEPTH - 1)) begin
                                state    <= FULL;
                                fetch_en <= 1'b0;
                            end else begin
                                fetch_en <= 1'b1;
                            end
                        end else if (pop) begin
                            state    <= FETCH;
                            fetch_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= HALTED;
                    fetch_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    // A flush discards the buffered entries plus the read that redirect squashed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (redirect_eff) begin
                flush_cnt <= flush_cnt + 16'(count) + 16'(fetch_en);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed scenarios then random
// traffic, compared every cycle against a queue-based reference model.
module tb_if_prefetch_queue;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_readM;
    logic [W-1:0]  i_address;
    logic [W-1:0]  i_data;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic          deq;
    logic          halt;
    logic          inst_valid;
    logic [W-1:0]  inst;
    logic [W-1:0]  inst_pc;
    logic [CW-1:0] count;
`ifdef PREFETCH_STATS_EN
    logic [15:0]   fetch_cnt;
    logic [15:0]   flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {pc, inst}, next fetch address, halted/armed flags.
    logic [31:0] mq[$];
    logic [15:0] m_pc;
    bit          m_halted;
    bit          m_armed;
    logic [15:0] m_fetch_cnt;
    logic [15:0] m_flush_cnt;

    always #5 clk = ~clk;

    // Instruction memory preload: mem[a] = A000 + a, read combinationally.
    assign i_data = 16'hA000 + i_address;

    if_prefetch_queue #(
        .WORD_SIZE (W),
        .DEPTH     (D),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_readM     (i_readM),
        .i_address   (i_address),
        .i_data      (i_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .halt        (halt),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .count       (count)
`ifdef PREFETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // A read is issued when fetching is live, there is room, and no live redirect.
    function automatic bit exp_read(input bit red);
        return m_armed && !m_halted && (mq.size() < D) && !(red && !m_halted);
    endfunction

    task automatic model_step(input bit rn, input bit red, input logic [15:0] rpc,
                              input bit dq, input bit hl);
        bit rd;
        rd = exp_read(red);
        if (!rn) begin
            mq.delete();
            m_pc        = 16'h0000;
            m_halted    = 1'b0;
            m_armed     = 1'b0;
            m_fetch_cnt = 16'h0000;
            m_flush_cnt = 16'h0000;
        end else if (red && !m_halted) begin
            m_flush_cnt = m_flush_cnt + 16'(mq.size()) + 16'(m_armed && (mq.size() < D));
            mq.delete();
            m_pc    = rpc;
            m_armed = 1'b1;
        end else begin
            if (dq && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (rd) begin
                mq.push_back({m_pc, 16'(16'hA000 + m_pc)});
                m_pc        = m_pc + 16'd1;
                m_fetch_cnt = m_fetch_cnt + 16'd1;
            end
            if (hl) begin
                m_halted = 1'b1;
            end
            m_armed = 1'b1;
        end
    endtask

    // Apply inputs after the falling edge, check outputs, then step through the rising edge.
    task automatic cycle(input bit rn, input bit red, input logic [15:0] rpc,
                         input bit dq, input bit hl, input bit chk = 1'b1);
        bit rd;
        reset_n     = rn;
        redirect    = red;
        redirect_pc = rpc;
        deq         = dq;
        halt        = hl;
        #1;
        if (chk) begin
            rd = exp_read(red);
            check_eq("i_readM", 32'(i_readM), 32'(rd));
            if (rd) begin
                check_eq("i_address", 32'(i_address), 32'(m_pc));
            end
            check_eq("count", 32'(count), 32'(mq.size()));
            check_eq("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check_eq("inst", 32'(inst), 32'(mq[0][15:0]));
                check_eq("inst_pc", 32'(inst_pc), 32'(mq[0][31:16]));
            end
`ifdef PREFETCH_STATS_EN
            check_eq("fetch_cnt", 32'(fetch_cnt), 32'(m_fetch_cnt));
            check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`endif
        end
        @(posedge clk);
        model_step(rn, red, rpc, dq, hl);
        @(negedge clk);
    endtask

    initial begin
        bit          rn;
        bit          red;
        logic [15:0] rpc;
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq         = 1'b0;
        halt        = 1'b0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Fill from reset until the queue is full.
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("fill_count", 32'(count), 32'(D));
        check_eq("fill_head", 32'(inst), 32'h0000_A000);

        // Drain continuously while refilling.
        repeat (8) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Redirect with a partially full queue.
        cycle(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        check_eq("redir_count", 32'(count), 32'h0);
        check_eq("redir_addr", 32'(i_address), 32'h0040);
        repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Fetch address wrap across FFFF.
        cycle(1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Halt, drain, ignored redirect, then reset back to fetching.
        cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 16'h0200, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            red = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'hFFFC + $urandom_range(0, 3));
            cycle(rn, red, rpc, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
